// File: rtl/clock_reset_broadcast_seq_if.sv
`default_nettype none
// ============================================================================
// Module   : clock_reset_broadcast_seq_if
// Purpose  : Consumer-facing bundle of the clock/reset broadcast sequencer.
// Revision : 1.0
// ============================================================================
interface clock_reset_broadcast_seq_if #(
    parameter int NUM_OUT = 4
);
    logic [NUM_OUT-1:0] soft_reset_req;
    logic [NUM_OUT-1:0] auto_out_clock;
    logic [NUM_OUT-1:0] auto_out_reset;
    logic               seq_done;
    logic               soft_busy;
    logic               soft_done;

    modport master (
        output soft_reset_req,
        input  auto_out_clock,
        input  auto_out_reset,
        input  seq_done,
        input  soft_busy,
        input  soft_done
    );

    modport slave (
        input  soft_reset_req,
        output auto_out_clock,
        output auto_out_reset,
        output seq_done,
        output soft_busy,
        output soft_done
    );
endinterface
`default_nettype wire

// File: rtl/clock_reset_broadcast_seq.sv
`default_nettype none
// ============================================================================
// Module   : clock_reset_broadcast_seq
// Purpose  : Clock fan-out with staggered power-on reset release and
//            per-channel software reset rounds.
// Revision : 1.0
// ============================================================================
module clock_reset_broadcast_seq #(
    parameter int NUM_OUT          = 4,
    parameter int HOLD_CYCLES      = 4,
    parameter int STAGGER_CYCLES   = 2,
    parameter int SOFT_HOLD_CYCLES = 2
) (
    input  wire logic                   auto_in_clock,
    input  wire logic                   auto_in_reset,
    clock_reset_broadcast_seq_if.slave  bus
);
    localparam int c_MAX_HS = (HOLD_CYCLES > STAGGER_CYCLES) ? HOLD_CYCLES : STAGGER_CYCLES;
    localparam int c_MAX    = (c_MAX_HS > SOFT_HOLD_CYCLES) ? c_MAX_HS : SOFT_HOLD_CYCLES;
    localparam int c_CNT_W  = $clog2(c_MAX + 1);

    localparam logic [c_CNT_W-1:0] c_HOLD_LOAD = c_CNT_W'(HOLD_CYCLES - 1);
    localparam logic [c_CNT_W-1:0] c_STAG_LOAD = c_CNT_W'((STAGGER_CYCLES > 0) ? STAGGER_CYCLES - 1 : 0);
    localparam logic [c_CNT_W-1:0] c_SOFT_LOAD = c_CNT_W'(SOFT_HOLD_CYCLES - 1);

    typedef enum logic [2:0] {
        S_ASSERT  = 3'd0,
        S_HOLD    = 3'd1,
        S_STAGGER = 3'd2,
        S_IDLE    = 3'd3,
        S_SOFT    = 3'd4
    } state_t;

    state_t               state_q, state_d;
    logic [c_CNT_W-1:0]   cnt_q, cnt_d;
    logic [NUM_OUT-1:0]   rst_q, rst_d;
    logic [NUM_OUT-1:0]   pend_q, pend_d;
    logic [NUM_OUT-1:0]   act_q, act_d;
    logic                 done_q, done_d;
    logic                 busy_q, busy_d;
    logic                 sdone_q, sdone_d;
    logic [NUM_OUT-1:0]   w_cleared;

    // Channels release in index order, so the next one is always the lowest still set.
    assign w_cleared = rst_q & (rst_q - NUM_OUT'(1));

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        rst_d   = rst_q;
        pend_d  = pend_q | bus.soft_reset_req;
        act_d   = act_q;
        done_d  = done_q;
        busy_d  = busy_q;
        sdone_d = 1'b0;
        case (state_q)
            S_ASSERT: begin
                rst_d   = '1;
                cnt_d   = c_HOLD_LOAD;
                state_d = S_HOLD;
            end
            S_HOLD: begin
                if (cnt_q == '0) begin
                    if (STAGGER_CYCLES == 0 || w_cleared == '0) begin
                        rst_d   = '0;
                        done_d  = 1'b1;
                        state_d = S_IDLE;
                    end else begin
                        rst_d   = w_cleared;
                        cnt_d   = c_STAG_LOAD;
                        state_d = S_STAGGER;
                    end
                end else begin
                    cnt_d = cnt_q - c_CNT_W'(1);
                end
            end
            S_STAGGER: begin
                if (cnt_q == '0) begin
                    rst_d = w_cleared;
                    cnt_d = c_STAG_LOAD;
                    if (w_cleared == '0) begin
                        done_d  = 1'b1;
                        state_d = S_IDLE;
                    end
                end else begin
                    cnt_d = cnt_q - c_CNT_W'(1);
                end
            end
            S_IDLE: begin
                // Requests seen on the start edge belong to the following round.
                if (pend_q != '0) begin
                    act_d   = pend_q;
                    pend_d  = bus.soft_reset_req;
                    rst_d   = rst_q | pend_q;
                    busy_d  = 1'b1;
                    cnt_d   = c_SOFT_LOAD;
                    state_d = S_SOFT;
                end
            end
            S_SOFT: begin
                if (cnt_q == '0) begin
                    rst_d   = rst_q & ~act_q;
                    busy_d  = 1'b0;
                    sdone_d = 1'b1;
                    state_d = S_IDLE;
                end else begin
                    cnt_d = cnt_q - c_CNT_W'(1);
                end
            end
            default: begin
                rst_d   = '1;
                state_d = S_ASSERT;
            end
        endcase
    end

    always_ff @(posedge auto_in_clock) begin
        if (auto_in_reset) begin
            state_q <= S_ASSERT;
            cnt_q   <= '0;
            rst_q   <= '1;
            pend_q  <= '0;
            act_q   <= '0;
            done_q  <= 1'b0;
            busy_q  <= 1'b0;
            sdone_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rst_q   <= rst_d;
            pend_q  <= pend_d;
            act_q   <= act_d;
            done_q  <= done_d;
            busy_q  <= busy_d;
            sdone_q <= sdone_d;
        end
    end

    assign bus.auto_out_clock = {NUM_OUT{auto_in_clock}};
    assign bus.auto_out_reset = rst_q;
    assign bus.seq_done       = done_q;
    assign bus.soft_busy      = busy_q;
    assign bus.soft_done      = sdone_q;
endmodule
`default_nettype wire
